cache_sa_wb: RTL and testbench
==============================

Name: cache_sa_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with one word per line, sitting between a CPU load/store port and a slower word-addressed memory.
- Each set keeps its own true-LRU replacement state.
- A miss FSM writes back the dirty victim, then refills the line, using a req/ack handshake on the memory side.

Parameters:
- ADDR_W, 30, word address width; tag width TAG_W = ADDR_W-INDEX_W.
- DATA_W, 32, data word width.
- INDEX_W, 10, set index width; 2**INDEX_W sets.
- WAYS, 4, associativity; power of two, 2..8; AGE_W = log2(WAYS).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_wr  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  word address; index = [INDEX_W-1:0], tag = upper bits.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle pulse completing every accepted request.
- resp_rdata  out  DATA_W  load data, valid with resp_valid; 0 for stores.
- resp_hit  out  1  with resp_valid: 1=hit, 0=miss.
- mem_req  out  1  memory request; held until mem_ack.
- mem_wr  out  1  1=write-back, 0=refill read.
- mem_addr  out  ADDR_W  word address, stable while mem_req.
- mem_wdata  out  DATA_W  write-back data, stable while mem_req.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_rdata  in  DATA_W  refill data, valid when mem_ack && !mem_wr.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE, so req_ready rises 1 cycle after reset release.
- Per line state: valid bit, dirty bit, TAG_W tag, DATA_W data.
- Per set: one AGE_W age per way.
- Valid, dirty and age are flops cleared by rst (age of way w reset to w). Tag and data arrays are not reset.
- FSM states: IDLE, LOOKUP, WRBACK, REFILL, RESP.
- IDLE: latch req_wr, req_addr and req_wdata on accept, then go to LOOKUP.
- LOOKUP: compare the tag against all valid ways.
  - Load hit: capture data.
  - Store hit: write word, set dirty.
  - Any hit: touch LRU, then go to RESP with hit=1.
  - Miss: choose victim = lowest-index invalid way, else the way with age == WAYS-1.
  - Victim valid and dirty: go to WRBACK. Otherwise go to REFILL.
- WRBACK: mem_req=1, mem_wr=1, mem_addr={victim tag,index}, mem_wdata=victim data. On mem_ack go to REFILL.
- REFILL: mem_req=1, mem_wr=0, mem_addr=latched address. On mem_ack:
  - Install {valid=1, tag, data} in the victim way and touch LRU.
  - Load: dirty=0, response data = mem_rdata.
  - Store: data=req_wdata (mem_rdata discarded), dirty=1.
  - Then go to RESP with hit=0.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Latency, with accept in cycle T:
  - Hit: resp_valid in T+2.
  - Clean miss with ack after k REFILL cycles: resp_valid in T+2+k.
  - Dirty miss: the write-back ack time is added.
- mem_req deasserts in the cycle after mem_ack is sampled. mem_ack while mem_req=0 is ignored.
- The next mem_req (REFILL after WRBACK) rises no earlier than 1 cycle after the WRBACK ack.
- LRU touch of way w with old age a: way w gets age 0; every way in the set with age < a increments. Ages within a set stay a permutation of 0..WAYS-1.
- Only the addressed set's state changes on any access.
- Duplicate tags never occur: a refill always targets the missing tag.
- Reset mid-miss: mem_req drops immediately (async); the in-flight request is dropped without resp_valid.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_cnt, miss_cnt and wb_cnt, each 32 bits.
  - hit_cnt/miss_cnt increment when resp_valid has resp_hit=1/0.
  - wb_cnt increments on each WRBACK mem_ack.
  - All saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- After reset, load 0x0000400 with mem_ack 3 cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_req/mem_wr=0/mem_addr=0x0000400; resp_valid with resp_rdata=0xDEADBEEF, resp_hit=0; repeat load -> resp_valid at T+2, resp_hit=1, no mem_req.
- Store 0x12345678 to 0x0000400 (hit), then reload -> resp_hit=1, rdata=0x12345678, no memory traffic.
- Loads to tags 1..4 at index 5 (fill 4 ways), reload tag 1, then load tag 5 -> victim is tag 2; a following load of tag 1 hits; a load of tag 2 misses.
- Make a line dirty via store 0xCAFEF00D to tag 1/index 5, then evict it -> WRBACK with mem_wr=1, mem_addr={tag1,5}, mem_wdata=0xCAFEF00D before the REFILL read.
- Store miss to an empty set -> single REFILL read, line installed dirty, resp_hit=0; a subsequent eviction writes back req_wdata.
- Assert rst while REFILL waits on mem_ack -> mem_req=0 immediately, no resp_valid; the same address then misses (valid cleared); with CACHE_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/cache_sa_wb.sv
// cache_sa_wb: N-way set-associative, write-back, write-allocate cache with
// one word per line and true-LRU replacement per set. Misses are served by a
// small FSM that writes back a dirty victim, then refills over a req/ack bus.
// Optional saturating hit/miss/write-back counters: define CACHE_PERF_CNT_EN.
module cache_sa_wb #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 10,
  parameter int WAYS    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRBACK,
    S_REFILL,
    S_RESP
  } state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_hit;
  logic                r_mem_req;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [AGE_W-1:0]    r_victim;

  // Per-set line state kept in flops so that reset can clear it.
  logic [WAYS-1:0]     r_valid [SETS];
  logic [WAYS-1:0]     r_dirty [SETS];
  logic [AGE_W-1:0]    r_age   [SETS][WAYS];

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_accept;
  logic [WAYS-1:0]     w_set_valid;
  logic [WAYS-1:0]     w_set_dirty;
  logic [WAYS-1:0]     w_hit_vec;
  logic                w_hit_any;
  logic [AGE_W-1:0]    w_hit_way;
  logic                w_inv_any;
  logic [AGE_W-1:0]    w_victim;
  logic                w_lookup_hit;
  logic                w_store_hit;
  logic                w_fill;
  logic                w_touch;
  logic [AGE_W-1:0]    w_touch_way;
  logic [AGE_W-1:0]    w_old_age;
  logic [DATA_W-1:0]   w_wr_data;
  logic [TAG_W-1:0]    w_rd_tag  [WAYS];
  logic [DATA_W-1:0]   w_rd_data [WAYS];

  assign w_idx        = r_addr[INDEX_W-1:0];
  assign w_tag        = r_addr[ADDR_W-1:INDEX_W];
  assign w_accept     = (r_state == S_IDLE) && r_req_ready && req_valid;
  assign w_set_valid  = r_valid[w_idx];
  assign w_set_dirty  = r_dirty[w_idx];
  assign w_lookup_hit = (r_state == S_LOOKUP) && w_hit_any;
  assign w_store_hit  = w_lookup_hit && r_wr;
  assign w_fill       = (r_state == S_REFILL) && r_mem_req && mem_ack;
  assign w_touch      = w_lookup_hit || w_fill;
  assign w_touch_way  = (r_state == S_LOOKUP) ? w_hit_way : r_victim;
  assign w_old_age    = r_age[w_idx][w_touch_way];
  // A refilled store keeps the CPU word and drops the memory word.
  assign w_wr_data    = (w_fill && !r_wr) ? mem_rdata : r_wdata;

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_hit   = r_resp_hit;
  assign mem_req    = r_mem_req;
  assign mem_wr     = r_mem_wr;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  // One tag RAM and one data RAM per way, read on request accept so the
  // registered outputs line up with the LOOKUP cycle.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]  r_tag_mem  [SETS];
      logic [DATA_W-1:0] r_data_mem [SETS];
      logic [TAG_W-1:0]  r_rd_tag;
      logic [DATA_W-1:0] r_rd_data;
      logic              w_tag_we;
      logic              w_data_we;

      assign w_tag_we  = w_fill && (r_victim == AGE_W'(gi));
      assign w_data_we = w_tag_we || (w_store_hit && (w_hit_way == AGE_W'(gi)));

      // Way RAM: synchronous write, registered read
      always_ff @(posedge clk) begin
        if (w_tag_we)  r_tag_mem[w_idx]  <= w_tag;
        if (w_data_we) r_data_mem[w_idx] <= w_wr_data;
        if (w_accept) begin
          r_rd_tag  <= r_tag_mem[req_addr[INDEX_W-1:0]];
          r_rd_data <= r_data_mem[req_addr[INDEX_W-1:0]];
        end
      end

      assign w_rd_tag[gi]  = r_rd_tag;
      assign w_rd_data[gi] = r_rd_data;
    end
  endgenerate

  // Tag match across valid ways and victim choice (lowest invalid, else LRU)
  always_comb begin
    w_hit_vec = '0;
    w_hit_any = 1'b0;
    w_hit_way = '0;
    w_inv_any = 1'b0;
    w_victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = w_set_valid[w] && (w_rd_tag[w] == w_tag);
      if (w_hit_vec[w]) begin
        w_hit_any = 1'b1;
        w_hit_way = AGE_W'(w);
      end
      if (r_age[w_idx][w] == AGE_W'(WAYS-1)) w_victim = AGE_W'(w);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!w_set_valid[w]) begin
        w_inv_any = 1'b1;
        w_victim  = AGE_W'(w);
      end
    end
  end

  // Valid, dirty and LRU age of the addressed set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= AGE_W'(w);
      end
    end else begin
      if (w_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == w_touch_way)
            r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < w_old_age)
            r_age[w_idx][w] <= r_age[w_idx][w] + AGE_W'(1);
        end
      end
      if (w_store_hit) r_dirty[w_idx][w_hit_way] <= 1'b1;
      if (w_fill) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= r_wr;
      end
    end
  end

  // Request/miss FSM with registered CPU and memory side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_hit   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_victim     <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_wr        <= req_wr;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit_any) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b1;
            r_resp_rdata <= r_wr ? '0 : w_rd_data[w_hit_way];
            r_state      <= S_RESP;
          end else begin
            r_victim  <= w_victim;
            r_mem_req <= 1'b1;
            if (!w_inv_any && w_set_dirty[w_victim]) begin
              r_mem_wr    <= 1'b1;
              r_mem_addr  <= {w_rd_tag[w_victim], w_idx};
              r_mem_wdata <= w_rd_data[w_victim];
              r_state     <= S_WRBACK;
            end else begin
              r_mem_wr    <= 1'b0;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= '0;
              r_state     <= S_REFILL;
            end
          end
        end
        S_WRBACK: begin
          if (r_mem_req && mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_state   <= S_REFILL;
          end
        end
        S_REFILL: begin
          // After a write-back the bus idles one cycle before the read.
          if (!r_mem_req) begin
            r_mem_req   <= 1'b1;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= '0;
          end else if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b0;
            r_resp_rdata <= r_wr ? '0 : mem_rdata;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_wb_cnt;

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (r_resp_valid && r_resp_hit && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (r_resp_valid && !r_resp_hit && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 32'd1;
      if ((r_state == S_WRBACK) && r_mem_req && mem_ack && (r_wb_cnt != '1))
        r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wb_cnt   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_cache_sa_wb.sv
// tb_cache_sa_wb: directed vector table, reset-mid-miss sequence and a
// randomized run checked against a recency-list cache model.
module tb_cache_sa_wb;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 10;
  localparam int WAYS    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wr = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  cache_sa_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    bit          exp_hit;
    logic [31:0] exp_rdata;
    bit          exp_wb;
    logic [29:0] exp_wb_addr;
    logic [31:0] exp_wb_data;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   mem_delay = 3;
  bit   mem_hold = 1'b0;
  txn_t txq[$];
  vec_t vq[$];

  // Memory as seen by the bus responder, and the model's own view of memory
  logic [31:0] phys  [logic [29:0]];
  logic [31:0] m_mem [logic [29:0]];
  // Model cache: per set a recency list of resident addresses (front = MRU)
  logic [29:0] m_set [1024][$];
  logic [31:0] m_cdata  [logic [29:0]];
  bit          m_cdirty [logic [29:0]];

  int tb_hits = 0, tb_miss = 0, tb_wb = 0;

  function automatic logic [31:0] fmem(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic logic [29:0] A(input int t, input int i);
    return 30'((t << 10) | i);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [29:0] a);
    return phys.exists(a) ? phys[a] : fmem(a);
  endfunction

  function automatic logic [31:0] mmem_rd(input logic [29:0] a);
    return m_mem.exists(a) ? m_mem[a] : fmem(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 1024; s++) m_set[s].delete();
    m_cdata.delete();
    m_cdirty.delete();
  endtask

  task automatic model_access(input bit wr, input logic [29:0] addr, input logic [31:0] wdata,
                              output bit hit, output logic [31:0] rdata,
                              output bit wb, output logic [29:0] wb_addr, output logic [31:0] wb_data);
    int idx = int'(addr[9:0]);
    int pos = -1;
    logic [29:0] vic;
    hit = 0; rdata = '0; wb = 0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < m_set[idx].size(); i++) if (m_set[idx][i] == addr) pos = i;
    if (pos >= 0) begin
      hit = 1;
      m_set[idx].delete(pos);
    end else if (m_set[idx].size() == WAYS) begin
      vic = m_set[idx].pop_back();
      if (m_cdirty[vic]) begin
        wb = 1; wb_addr = vic; wb_data = m_cdata[vic];
        m_mem[vic] = m_cdata[vic];
      end
      m_cdata.delete(vic);
      m_cdirty.delete(vic);
    end
    m_set[idx].push_front(addr);
    if (!hit) begin
      m_cdata[addr]  = mmem_rd(addr);
      m_cdirty[addr] = 0;
    end
    if (wr) begin
      m_cdata[addr]  = wdata;
      m_cdirty[addr] = 1;
    end else begin
      rdata = m_cdata[addr];
    end
  endtask

  task automatic do_req(input bit wr, input logic [29:0] addr, input logic [31:0] wdata,
                        output bit hit, output logic [31:0] rdata, output int lat);
    int n = 0;
    hit = 0; rdata = '0; lat = 0;
    txq.delete();
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_wait", req_ready, 1);
    if (req_ready !== 1'b1) return;
    req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_wr = 0; req_addr = 30'($urandom); req_wdata = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 300) begin @(negedge clk); lat++; end
    chk("resp_timeout", resp_valid, 1);
    if (resp_valid !== 1'b1) return;
    hit = resp_hit; rdata = resp_rdata;
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);
  endtask

  task automatic check_txns(input bit miss, input bit wb, input logic [29:0] wb_addr,
                            input logic [31:0] wb_data, input logic [29:0] addr);
    int n_exp = (miss ? 1 : 0) + (wb ? 1 : 0);
    int k = 0;
    chk("mem_txn_count", txq.size(), n_exp);
    if (txq.size() != n_exp) return;
    if (wb) begin
      chk("wb_wr", txq[0].wr, 1);
      chk("wb_addr", txq[0].addr, wb_addr);
      chk("wb_data", txq[0].wdata, wb_data);
      k = 1;
    end
    if (miss) begin
      chk("refill_wr", txq[k].wr, 0);
      chk("refill_addr", txq[k].addr, addr);
    end
  endtask

  task automatic add_vec(input bit wr, input logic [29:0] addr, input logic [31:0] wdata,
                         input bit eh, input logic [31:0] er, input bit ewb,
                         input logic [29:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_hit = eh; v.exp_rdata = er;
    v.exp_wb = ewb; v.exp_wb_addr = ewa; v.exp_wb_data = ewd;
    vq.push_back(v);
  endtask

  // Bus responder: logs each request, acks after a delay, checks hold/drop rules
  initial begin : responder
    txn_t t;
    int   d;
    bit   ab;
    mem_ack = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && rst === 1'b0) begin
        t.wr = mem_wr; t.addr = mem_addr; t.wdata = mem_wdata;
        txq.push_back(t);
        d  = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
        ab = 0;
        while (!ab && (d > 0 || mem_hold)) begin
          @(negedge clk);
          if (mem_req !== 1'b1) ab = 1;
          else chk("mem_req_stable", {mem_wr, mem_addr, mem_wdata}, {t.wr, t.addr, t.wdata});
          if (d > 0) d--;
        end
        if (!ab) begin
          mem_ack = 1;
          if (t.wr) begin
            mem_rdata = $urandom;
            phys[t.addr] = t.wdata;
          end else begin
            mem_rdata = phys_rd(t.addr);
          end
          @(negedge clk);
          mem_ack = 0;
          mem_rdata = $urandom;
          chk("mem_req_drop", mem_req, 0);
        end
      end
    end
  end

  initial begin : main
    bit          a_hit, m_hit, m_wb, wr;
    logic [31:0] a_rdata, m_rdata, m_wbd, wd;
    logic [29:0] m_wba, addr_r;
    int          a_lat, n;

    // Directed table
    add_vec(0, 30'h400, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    add_vec(0, 30'h400, 0, 1, 32'hDEADBEEF, 0, 0, 0);
    add_vec(1, 30'h400, 32'h12345678, 1, 0, 0, 0, 0);
    add_vec(0, 30'h400, 0, 1, 32'h12345678, 0, 0, 0);
    for (int t = 1; t <= 4; t++) add_vec(0, A(t, 5), 0, 0, fmem(A(t, 5)), 0, 0, 0);
    add_vec(0, A(1, 5), 0, 1, fmem(A(1, 5)), 0, 0, 0);
    add_vec(0, A(5, 5), 0, 0, fmem(A(5, 5)), 0, 0, 0);
    add_vec(0, A(1, 5), 0, 1, fmem(A(1, 5)), 0, 0, 0);
    add_vec(0, A(2, 5), 0, 0, fmem(A(2, 5)), 0, 0, 0);
    add_vec(1, A(1, 5), 32'hCAFEF00D, 1, 0, 0, 0, 0);
    add_vec(0, A(2, 5), 0, 1, fmem(A(2, 5)), 0, 0, 0);
    add_vec(0, A(5, 5), 0, 1, fmem(A(5, 5)), 0, 0, 0);
    add_vec(0, A(4, 5), 0, 1, fmem(A(4, 5)), 0, 0, 0);
    add_vec(0, A(6, 5), 0, 0, fmem(A(6, 5)), 1, A(1, 5), 32'hCAFEF00D);
    add_vec(1, A(3, 9), 32'h0BADF00D, 0, 0, 0, 0, 0);
    for (int t = 4; t <= 6; t++) add_vec(0, A(t, 9), 0, 0, fmem(A(t, 9)), 0, 0, 0);
    add_vec(0, A(7, 9), 0, 0, fmem(A(7, 9)), 1, A(3, 9), 32'h0BADF00D);
    add_vec(0, A(1, 5), 0, 0, 32'hCAFEF00D, 0, 0, 0);

    phys[30'h400]  = 32'hDEADBEEF;
    m_mem[30'h400] = 32'hDEADBEEF;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 0;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1);

    foreach (vq[i]) begin
      do_req(vq[i].wr, vq[i].addr, vq[i].wdata, a_hit, a_rdata, a_lat);
      model_access(vq[i].wr, vq[i].addr, vq[i].wdata, m_hit, m_rdata, m_wb, m_wba, m_wbd);
      $display("vec %0d wr=%0d addr=%h wdata=%h hit=%0d rdata=%h lat=%0d mem_txns=%0d",
               i, vq[i].wr, vq[i].addr, vq[i].wdata, a_hit, a_rdata, a_lat, txq.size());
      chk($sformatf("vec%0d_hit", i), a_hit, vq[i].exp_hit);
      chk($sformatf("vec%0d_rdata", i), a_rdata, vq[i].exp_rdata);
      if (vq[i].exp_hit) chk($sformatf("vec%0d_hit_latency", i), a_lat, 2);
      check_txns(!vq[i].exp_hit, vq[i].exp_wb, vq[i].exp_wb_addr, vq[i].exp_wb_data, vq[i].addr);
    end

    // Reset while a refill waits for its ack
    mem_hold = 1; mem_delay = 0;
    addr_r = A(2, 100);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    req_valid = 1; req_wr = 0; req_addr = addr_r;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rstmid_mem_req_up", mem_req, 1);
    chk("rstmid_refill_addr", mem_addr, addr_r);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_resp_before", resp_valid, 0);
    end
    #2 rst = 1;
    #1;
    chk("rstmid_async_mem_req", mem_req, 0);
    chk("rstmid_resp_valid", resp_valid, 0);
    chk("rstmid_req_ready", req_ready, 0);
    @(negedge clk);
    chk("rstmid_no_resp_during", resp_valid, 0);
    @(negedge clk);
    rst = 0;
    mem_hold = 0;
    model_reset();
`ifdef CACHE_PERF_CNT_EN
    chk("rstmid_hit_cnt", hit_cnt, 0);
    chk("rstmid_miss_cnt", miss_cnt, 0);
    chk("rstmid_wb_cnt", wb_cnt, 0);
`endif
    @(negedge clk);
    chk("rstmid_req_ready_back", req_ready, 1);
    chk("rstmid_no_resp_after", resp_valid, 0);
    do_req(0, addr_r, 0, a_hit, a_rdata, a_lat);
    model_access(0, addr_r, 0, m_hit, m_rdata, m_wb, m_wba, m_wbd);
    tb_miss++;
    $display("post-reset wr=0 addr=%h hit=%0d rdata=%h lat=%0d", addr_r, a_hit, a_rdata, a_lat);
    chk("rstmid_readdr_miss", a_hit, 0);
    chk("rstmid_readdr_rdata", a_rdata, fmem(addr_r));
    check_txns(1, 0, 0, 0, addr_r);

    // Randomized traffic over a few sets and tags
    mem_delay = -1;
    for (int i = 0; i < 250; i++) begin
      wr   = ($urandom_range(0, 9) < 4);
      addr_r = A(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      wd   = $urandom;
      do_req(wr, addr_r, wd, a_hit, a_rdata, a_lat);
      model_access(wr, addr_r, wd, m_hit, m_rdata, m_wb, m_wba, m_wbd);
      if (m_hit) tb_hits++; else tb_miss++;
      if (m_wb) tb_wb++;
      $display("rnd %0d wr=%0d addr=%h wdata=%h hit=%0d rdata=%h lat=%0d mem_txns=%0d",
               i, wr, addr_r, wd, a_hit, a_rdata, a_lat, txq.size());
      chk("rnd_hit", a_hit, m_hit);
      chk("rnd_rdata", a_rdata, m_rdata);
      if (m_hit) chk("rnd_hit_latency", a_lat, 2);
      check_txns(!m_hit, m_wb, m_wba, m_wbd, addr_r);
    end

`ifdef CACHE_PERF_CNT_EN
    chk("perf_hit_cnt", hit_cnt, tb_hits);
    chk("perf_miss_cnt", miss_cnt, tb_miss);
    chk("perf_wb_cnt", wb_cnt, tb_wb);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
